// File: rtl/mdl_memory_pkg.sv
// mdl_memory_pkg: shared width helpers and pointer wrap for the mdl_memory FIFO controller.
package mdl_memory_pkg;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  // Explicit wrap so non-power-of-two depths stay inside the array.
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/mdl_memory_fifo_ptr.sv
// mdl_memory_fifo_ptr: wrapping address pointer with increment and synchronous clear.
module mdl_memory_fifo_ptr import mdl_memory_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [ptr_w(DEPTH)-1:0]  ptr
);
  localparam int PW = ptr_w(DEPTH);
  always_ff @(posedge clk)
    if (rst || clr) ptr <= '0;
    else if (inc) ptr <= PW'(next_ptr(int'(ptr), DEPTH));
endmodule

// File: rtl/mdl_memory_fifo_ctrl.sv
// mdl_memory_fifo_ctrl: runs an mdl_memory dual-port array as a synchronous valid/ready FIFO.
module mdl_memory_fifo_ctrl import mdl_memory_pkg::*; #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int AFULL_TH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         pop_data,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     mem_vld_in,
  output logic [ptr_w(DEPTH)-1:0]  mem_wr_addr,
  output logic [WIDTH-1:0]         mem_data_in,
  output logic                     mem_vld_out,
  output logic [ptr_w(DEPTH)-1:0]  mem_rd_addr,
  input  logic [WIDTH-1:0]         mem_data_out
);
  localparam int CW = cnt_w(DEPTH);
  logic push_fire, pop_fire;
  assign full        = count == CW'(DEPTH);
  assign empty       = count == '0;
  assign almost_full = count >= CW'(AFULL_TH);
  assign push_ready  = !full;
  assign pop_valid   = !empty;
  assign push_fire   = push_valid & push_ready;
  assign pop_fire    = pop_valid & pop_ready;
  assign mem_vld_in  = push_fire;
  assign mem_data_in = push_data;
  assign mem_vld_out = !empty;
  assign pop_data    = mem_data_out;
  mdl_memory_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk(clk), .rst(rst), .clr(flush), .inc(push_fire), .ptr(mem_wr_addr)
  );
  mdl_memory_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk(clk), .rst(rst), .clr(flush), .inc(pop_fire), .ptr(mem_rd_addr)
  );
  // Error flags survive flush; only rst clears them.
  always_ff @(posedge clk)
    if (rst) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_valid && full) overflow <= 1'b1;
      if (pop_ready && empty) underflow <= 1'b1;
      count <= flush ? '0 : count + CW'(push_fire) - CW'(pop_fire);
    end
endmodule

// File: tb/tb_mdl_memory_fifo_ctrl.sv
// tb_mdl_memory_fifo_ctrl: directed FIFO scenarios checked against a queue model every cycle.
module tb_mdl_memory_fifo_ctrl;
  logic       clk = 0, rst = 1, flush = 0;
  logic       push_valid = 0, pop_ready = 0;
  logic [7:0] push_data = 0;
  logic       push_ready, pop_valid, full, empty, almost_full, overflow, underflow;
  logic [7:0] pop_data, mem_data_in, mem_data_out;
  logic [4:0] count;
  logic       mem_vld_in, mem_vld_out;
  logic [3:0] mem_wr_addr, mem_rd_addr;
  int tests = 0, fails = 0;
  bit checking = 0;
  always #5 clk = ~clk;
  mdl_memory_fifo_ctrl #(.DEPTH(16), .WIDTH(8), .AFULL_TH(12)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow),
    .mem_vld_in(mem_vld_in), .mem_wr_addr(mem_wr_addr), .mem_data_in(mem_data_in),
    .mem_vld_out(mem_vld_out), .mem_rd_addr(mem_rd_addr), .mem_data_out(mem_data_out)
  );
  // mdl_memory stand-in: zeroed on rst, combinational read port.
  logic [7:0] mem [16];
  always @(posedge clk)
    if (rst) foreach (mem[i]) mem[i] <= 8'h00;
    else if (mem_vld_in) mem[mem_wr_addr] <= mem_data_in;
  assign mem_data_out = mem_vld_out ? mem[mem_rd_addr] : 8'h00;
  // Reference model: queue of stored words plus sticky error bits.
  logic [7:0] q[$];
  bit m_ovf = 0, m_udf = 0;
  always @(posedge clk) begin
    bit pf, qf;
    if (rst) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      if (push_valid && q.size() == 16) m_ovf = 1;
      if (pop_ready && q.size() == 0) m_udf = 1;
      if (flush) q.delete();
      else begin
        pf = push_valid && q.size() < 16;
        qf = pop_ready && q.size() > 0;
        if (qf) void'(q.pop_front());
        if (pf) q.push_back(push_data);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (checking) begin
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_full", 32'(full), 32'(q.size() == 16));
      chk("m_afull", 32'(almost_full), 32'(q.size() >= 12));
      chk("m_push_ready", 32'(push_ready), 32'(q.size() < 16));
      chk("m_pop_valid", 32'(pop_valid), 32'(q.size() > 0));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_udf));
      if (q.size() > 0) chk("m_pop_data", 32'(pop_data), 32'(q[0]));
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      push_valid = 1;
      push_data = base + 8'(i);
      tick();
    end
    push_valid = 0;
  endtask
  task automatic pop_n(input int n, input logic [7:0] base, input string name);
    pop_ready = 1;
    for (int i = 0; i < n; i++) begin
      chk(name, 32'(pop_data), 32'(base + 8'(i)));
      tick();
    end
    pop_ready = 0;
  endtask
  initial begin
    tick();
    tick();
    checking = 1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_push_ready", 32'(push_ready), 1);
    chk("rst_pop_valid", 32'(pop_valid), 0);
    rst = 0;
    // 1: fill to full
    for (int i = 1; i <= 16; i++) begin
      push_valid = 1;
      push_data = 8'(i);
      tick();
      chk("t1_afull", 32'(almost_full), 32'(i >= 12));
      chk("t1_full", 32'(full), 32'(i == 16));
    end
    push_valid = 0;
    chk("t1_count", 32'(count), 16);
    chk("t1_push_ready", 32'(push_ready), 0);
    // 2: drain in order
    pop_n(16, 8'h01, "t2_pop_data");
    chk("t2_empty", 32'(empty), 1);
    chk("t2_overflow", 32'(overflow), 0);
    chk("t2_underflow", 32'(underflow), 0);
    // 3: streaming at depth 8 across two wraps
    push_n(8, 8'h20);
    push_valid = 1;
    pop_ready = 1;
    for (int k = 0; k < 40; k++) begin
      push_data = 8'h28 + 8'(k);
      chk("t3_pop_data", 32'(pop_data), 32'(8'h20 + 8'(k)));
      tick();
      chk("t3_count", 32'(count), 8);
    end
    push_valid = 0;
    pop_ready = 0;
    pop_n(8, 8'h48, "t3_tail");
    // 4: overflow while full, then pop+push from full
    push_n(16, 8'h60);
    push_valid = 1;
    push_data = 8'hAA;
    tick();
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_count", 32'(count), 16);
    push_valid = 0;
    tick();
    chk("t4_sticky", 32'(overflow), 1);
    push_valid = 1;
    pop_ready = 1;
    chk("t4_head", 32'(pop_data), 32'h60);
    tick();
    push_valid = 0;
    pop_ready = 0;
    chk("t4_count15", 32'(count), 15);
    pop_n(15, 8'h61, "t4_drain");
    chk("t4_empty", 32'(empty), 1);
    chk("t4_no_udf", 32'(underflow), 0);
    // 5: pop on empty with a simultaneous push
    pop_ready = 1;
    push_valid = 1;
    push_data = 8'h5C;
    chk("t5_pop_valid0", 32'(pop_valid), 0);
    tick();
    push_valid = 0;
    chk("t5_underflow", 32'(underflow), 1);
    chk("t5_pop_valid1", 32'(pop_valid), 1);
    chk("t5_pop_data", 32'(pop_data), 32'h5C);
    tick();
    pop_ready = 0;
    chk("t5_empty", 32'(empty), 1);
    // 6: flush drops contents and a concurrent push, keeps error flags
    push_n(5, 8'h70);
    chk("t6_count5", 32'(count), 5);
    flush = 1;
    push_valid = 1;
    push_data = 8'h99;
    tick();
    flush = 0;
    push_valid = 0;
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_overflow", 32'(overflow), 1);
    chk("t6_underflow", 32'(underflow), 1);
    // reset in the middle of streaming
    push_n(3, 8'h80);
    push_valid = 1;
    pop_ready = 1;
    for (int k = 0; k < 3; k++) begin
      push_data = 8'h90 + 8'(k);
      tick();
    end
    rst = 1;
    tick();
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_empty", 32'(empty), 1);
    chk("t6_rst_full", 32'(full), 0);
    chk("t6_rst_afull", 32'(almost_full), 0);
    chk("t6_rst_push_ready", 32'(push_ready), 1);
    chk("t6_rst_pop_valid", 32'(pop_valid), 0);
    chk("t6_rst_ovf", 32'(overflow), 0);
    chk("t6_rst_udf", 32'(underflow), 0);
    rst = 0;
    push_valid = 0;
    pop_ready = 0;
    push_n(2, 8'hC0);
    pop_n(2, 8'hC0, "t6_after_rst");
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
